// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter with a per-frame latched baud divisor.
// Frame: start bit, 8 data bits LSB first, optional parity bit, one stop bit.
// Optional feature macro: UART_TX_PARITY_EN. It enables the parity bit stage.
// Without it, the parity inputs are ignored and every frame is 10 bits long.
// Handshake: a write is taken on a rising edge where i_we_h=1, i_en_h=1 and o_busy_h=0.
// o_busy_h rises on that same edge. Writes seen while o_busy_h=1 are dropped.
module uart_tx #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en_h,
    input  logic [DIV_W-1:0] i_div,
    input  logic [7:0]       i_tx_data,
    input  logic             i_we_h,
    input  logic             i_parity_en_h,
    input  logic             i_parity_type_el_oh,
    output logic             o_tx,
    output logic             o_busy_h
);

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state;
    logic [7:0]       shift_q;   // remaining data bits, next bit to send in [0]
    logic [DIV_W-1:0] div_q;     // latched clocks-per-bit, never zero
    logic [DIV_W-1:0] div_cnt;   // clocks already spent on the current bit
    logic [2:0]       bit_cnt;   // index of the data bit on the line
    logic             bit_done;
    logic [DIV_W-1:0] div_eff;

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_bit_q;
`else
    logic unused_parity;
    assign unused_parity = i_parity_en_h ^ i_parity_type_el_oh;
`endif

    // A divisor of zero is treated as one clock per bit.
    assign div_eff  = (i_div == '0) ? ONE : i_div;
    assign bit_done = (div_cnt == div_q - ONE);

    // Frame sequencer. o_tx and o_busy_h are registered here directly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            shift_q  <= '0;
            div_q    <= ONE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            o_tx     <= 1'b1;
            o_busy_h <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else if (!i_en_h) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            o_tx     <= 1'b1;
            o_busy_h <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_we_h) begin
                        shift_q  <= i_tx_data;
                        div_q    <= div_eff;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        o_tx     <= 1'b0;
                        o_busy_h <= 1'b1;
                        state    <= START;
`ifdef UART_TX_PARITY_EN
                        par_en_q  <= i_parity_en_h;
                        par_bit_q <= (^i_tx_data) ^ i_parity_type_el_oh;
`endif
                    end
                end
                START: begin
                    if (bit_done) begin
                        div_cnt <= '0;
                        o_tx    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state   <= DATA;
                    end else begin
                        div_cnt <= div_cnt + ONE;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        div_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            if (par_en_q) begin
                                o_tx  <= par_bit_q;
                                state <= PARITY;
                            end else begin
                                o_tx  <= 1'b1;
                                state <= STOP;
                            end
`else
                            o_tx  <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            o_tx    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        div_cnt <= div_cnt + ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        div_cnt <= '0;
                        o_tx    <= 1'b1;
                        state   <= STOP;
                    end else begin
                        div_cnt <= div_cnt + ONE;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        div_cnt  <= '0;
                        o_busy_h <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + ONE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    o_tx     <= 1'b1;
                    o_busy_h <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx.
// Each write pushes its expected per-clock line levels into exp_q.
// A negedge monitor pops one entry per busy clock and compares it with o_tx.
module tb_uart_tx;

    localparam int DIV_W = 16;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [DIV_W-1:0] div;
    logic [7:0]       tx_data;
    logic             we;
    logic             par_en;
    logic             par_odd;
    logic             tx;
    logic             busy;

    logic [0:0] exp_q[$];
    int         tests;
    int         fails;
    logic       mon_on;

    uart_tx #(.DIV_W(DIV_W)) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_en_h              (en),
        .i_div               (div),
        .i_tx_data           (tx_data),
        .i_we_h              (we),
        .i_parity_en_h       (par_en),
        .i_parity_type_el_oh (par_odd),
        .o_tx                (tx),
        .o_busy_h            (busy)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: one expected line level per busy clock, line high when idle
    always @(negedge clk) begin
        if (mon_on && rst_n) begin
            if (busy) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_busy: got busy=1 expected no frame at %0t", $time);
                end else begin
                    check("line_bit", {31'b0, tx}, {31'b0, exp_q.pop_front()});
                end
            end else begin
                check("idle_line", {31'b0, tx}, 32'd1);
            end
        end
    end

    task automatic push_frame(input logic [10:0] frame, input int nbits, input int d);
        for (int i = 0; i < nbits; i++)
            for (int j = 0; j < d; j++)
                exp_q.push_back(frame[i]);
    endtask

    // returns at the first negedge where busy reads 0
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got busy=1 expected 0 after %0d clocks", n);
        end
    endtask

    task automatic check_drained(input string name);
        check(name, exp_q.size(), 32'd0);
    endtask

    // write on the first idle clock; frame bits listed LSB = first on the line
    task automatic do_write(input logic [7:0] d, input logic [10:0] frame, input int nbits, input int dv);
        wait_idle();
        push_frame(frame, nbits, dv);
        tx_data = d;
        we      = 1'b1;
        @(negedge clk);
        we = 1'b0;
        check("accept_busy", {31'b0, busy}, 32'd1);
        check("start_bit", {31'b0, tx}, 32'd0);
    endtask

    task automatic pulse_we(input logic [7:0] d);
        tx_data = d;
        we      = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        mon_on  = 1'b0;
        rst_n   = 1'b1;
        en      = 1'b1;
        div     = 16'd4;
        tx_data = 8'h00;
        we      = 1'b0;
        par_en  = 1'b0;
        par_odd = 1'b0;

        // reset: outputs forced before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("reset_tx", {31'b0, tx}, 32'd1);
        check("reset_busy", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_on = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5, div 4: 0,1,0,1,0,0,1,0,1,1 for 40 busy clocks
        do_write(8'hA5, 11'h34A, 10, 4);
        wait_idle();
        check_drained("a5_length");

`ifdef UART_TX_PARITY_EN
        // 0x31 has three ones: even parity bit 1, odd parity bit 0, 33 clocks each
        div    = 16'd3;
        par_en = 1'b1;
        par_odd = 1'b0;
        do_write(8'h31, 11'h662, 11, 3);
        wait_idle();
        check_drained("par_even_length");
        par_odd = 1'b1;
        do_write(8'h31, 11'h462, 11, 3);
        wait_idle();
        check_drained("par_odd_length");
`else
        // parity inputs have no effect in this build: plain 10-bit frame
        div     = 16'd3;
        par_en  = 1'b1;
        par_odd = 1'b1;
        do_write(8'h31, 11'h262, 10, 3);
        wait_idle();
        check_drained("noparity_length");
`endif
        par_en  = 1'b0;
        par_odd = 1'b0;

        // write while busy is dropped; mid-frame divisor/parity changes wait for next frame
        div = 16'd4;
        do_write(8'h0A, 11'h214, 10, 4);
        repeat (3) @(negedge clk);
        div    = 16'd7;
        par_en = 1'b1;
        pulse_we(8'hFF);
        wait_idle();
        check_drained("ignored_write");
        repeat (12) @(negedge clk);
        check("ignored_idle", {31'b0, busy}, 32'd0);
        div    = 16'd4;
        par_en = 1'b0;

        // divisor zero behaves as one clock per bit
        div = 16'd0;
        do_write(8'hA5, 11'h34A, 10, 1);
        wait_idle();
        check_drained("div0_length");

        // back-to-back at div 108, second write on the first non-busy clock
        div = 16'd108;
        do_write(8'h30, 11'h260, 10, 108);
        do_write(8'h31, 11'h262, 10, 108);
        wait_idle();
        check_drained("b2b_length");

        // asynchronous reset mid-frame, then a clean frame
        div = 16'd4;
        do_write(8'h55, 11'h2AA, 10, 4);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_tx", {31'b0, tx}, 32'd1);
        check("midreset_busy", {31'b0, busy}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_write(8'h55, 11'h2AA, 10, 4);
        wait_idle();
        check_drained("after_reset_length");

        // disable during DATA aborts; writes while disabled are ignored
        do_write(8'h55, 11'h2AA, 10, 4);
        repeat (6) @(negedge clk);
        en = 1'b0;
        #1 exp_q.delete();
        @(negedge clk);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_tx", {31'b0, tx}, 32'd1);
        pulse_we(8'h5A);
        repeat (20) @(negedge clk);
        check("disabled_busy", {31'b0, busy}, 32'd0);
        en = 1'b1;
        do_write(8'h0A, 11'h214, 10, 4);
        wait_idle();
        check_drained("after_enable_length");

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
